// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: shared divider width, FSM state type and two's-complement helper
package mips_alu_pkg;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {IDLE, RUN, FIN} div_state_t;
    function automatic logic [DATA_W-1:0] neg2c(input logic [DATA_W-1:0] x);
        return ~x + DATA_W'(1);
    endfunction
endpackage

// File: rtl/mips_div_unit_if.sv
// mips_div_unit_if: start/busy/done divider bus between the EX stage and the divider
interface mips_div_unit_if #(parameter int W = mips_alu_pkg::DATA_W);
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    modport master(
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave(
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/mips_div_step.sv
// mips_div_step: one restoring shift-subtract iteration producing one quotient bit
module mips_div_step
    import mips_alu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] rem,
    input  logic         dvd_msb,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);
    logic [W-1:0] rem_sh;
    logic [W:0]   trial;
    assign rem_sh   = {rem[W-2:0], dvd_msb};
    assign trial    = {rem[W-1], rem_sh} - {1'b0, dvs};
    assign q_bit    = ~trial[W];
    assign rem_next = q_bit ? trial[W-1:0] : rem_sh;
endmodule

// File: rtl/mips_div_unit.sv
// mips_div_unit: multi-cycle restoring divider for MIPS DIV/DIVU feeding HI/LO
module mips_div_unit
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic            clk,
    input  logic            reset,
    mips_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic             done_q, done_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] step_rem, a_mag, b_mag;
    logic             step_q, a_neg, b_neg, zero_dvs;
    mips_div_step #(.W(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[WIDTH-1]),
        .dvs      (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );
    assign a_neg    = bus.is_signed & bus.dividend[WIDTH-1];
    assign b_neg    = bus.is_signed & bus.divisor[WIDTH-1];
    assign a_mag    = a_neg ? neg2c(bus.dividend) : bus.dividend;
    assign b_mag    = b_neg ? neg2c(bus.divisor) : bus.divisor;
    assign zero_dvs = bus.divisor == '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end
    always_comb begin
        state_d = state_q == IDLE ? (bus.start ? (zero_dvs ? FIN : RUN) : IDLE)
                : state_q == RUN  ? (cnt_q == '0 ? FIN : RUN)
                : IDLE;
    end
    // Divide-by-zero parks the raw dividend in rem_q and all ones in dvd_q so FIN passes them through unsigned.
    always_comb begin
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        quo_d  = quo_q;
        rmd_d  = rmd_q;
        cnt_d  = cnt_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        dbz_d  = dbz_q;
        done_d = state_q == FIN;
        if (state_q == IDLE && bus.start) begin
            dz_d   = zero_dvs;
            qneg_d = !zero_dvs && (a_neg ^ b_neg);
            rneg_d = !zero_dvs && a_neg;
            rem_d  = zero_dvs ? bus.dividend : '0;
            dvd_d  = zero_dvs ? '1 : a_mag;
            dvs_d  = b_mag;
            cnt_d  = CW'(WIDTH - 1);
            dbz_d  = 1'b0;
        end
        if (state_q == RUN) begin
            rem_d = step_rem;
            dvd_d = {dvd_q[WIDTH-2:0], step_q};
            cnt_d = cnt_q - CW'(1);
        end
        if (state_q == FIN) begin
            quo_d = qneg_q ? neg2c(dvd_q) : dvd_q;
            rmd_d = rneg_q ? neg2c(rem_q) : rem_q;
            dbz_d = dz_q;
        end
    end
    always_comb begin
        bus.busy        = state_q != IDLE;
        bus.done        = done_q;
        bus.quotient    = quo_q;
        bus.remainder   = rmd_q;
        bus.div_by_zero = dbz_q;
    end
endmodule

// File: tb/tb_mips_div_unit.sv
// tb_mips_div_unit: directed table, handshake corner cases and a random sweep against a reference model
module tb_mips_div_unit;
    import mips_alu_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    mips_div_unit_if #(.W(DATA_W)) bus();
    mips_div_unit #(.WIDTH(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    int n_cmp = 0;
    int n_fail = 0;
    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;
    vec_t vecs[12];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        #1;
    endtask
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (!bus.done && lat < 100) begin
            busy_n += int'(bus.busy);
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.done) check("done_timeout", 32'(bus.done), 32'd1);
    endtask
    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output logic dz);
        logic an, bn;
        logic [31:0] ma, mb;
        an = s & a[31];
        bn = s & b[31];
        ma = an ? 32'd0 - a : a;
        mb = bn ? 32'd0 - b : b;
        dz = b == 32'd0;
        if (dz) begin
            q = '1;
            r = a;
        end else begin
            q = ma / mb;
            r = ma % mb;
            if (an ^ bn) q = 32'd0 - q;
            if (an) r = 32'd0 - r;
        end
    endfunction
    initial begin
        int lat, bn;
        logic seen;
        logic [31:0] eq, er, a, b;
        logic edz, s;
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
        vecs[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
        vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
        vecs[6]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[8]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1};
        vecs[9]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
        vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
        vecs[11] = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_q", bus.quotient, 32'd0);
        check("reset_r", bus.remainder, 32'd0);
        check("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].s, vecs[i].a, vecs[i].b);
            bus.start = 1'b0;
            check("dbz_cleared_on_start", 32'(bus.div_by_zero), 32'd0);
            wait_done(lat, bn);
            check("vec_q", bus.quotient, vecs[i].q);
            check("vec_r", bus.remainder, vecs[i].r);
            check("vec_dbz", 32'(bus.div_by_zero), 32'(vecs[i].dz));
            check("vec_latency", 32'(lat), vecs[i].dz ? 32'd1 : 32'd33);
            check("vec_busy_cycles", 32'(bn), vecs[i].dz ? 32'd1 : 32'd33);
            check("vec_busy_at_done", 32'(bus.busy), 32'd0);
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("results_held_q", bus.quotient, 32'hFFFFFFF2);
        launch(1'b0, 32'd100, 32'd7);
        bus.is_signed = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor = 32'd3;
        wait_done(lat, bn);
        check("held_start_q", bus.quotient, 32'd14);
        check("held_start_r", bus.remainder, 32'd2);
        check("held_start_latency", 32'(lat), 32'd33);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(lat, bn);
        check("b2b_q", bus.quotient, 32'd333);
        check("b2b_r", bus.remainder, 32'd1);
        check("b2b_latency", 32'(lat), 32'd33);
        launch(1'b0, 32'd100, 32'd7);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_q", bus.quotient, 32'd0);
        check("abort_r", bus.remainder, 32'd0);
        check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 255);
                3:       b = 32'd0 - 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            ref_div(s, a, b, eq, er, edz);
            launch(s, a, b);
            bus.start = 1'b0;
            wait_done(lat, bn);
            check("rand_q", bus.quotient, eq);
            check("rand_r", bus.remainder, er);
            check("rand_dbz", 32'(bus.div_by_zero), 32'(edz));
            if (b != 32'd0) check("rand_invariant", bus.quotient * b + bus.remainder, a);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
